// File: rtl/stream_to_axi.sv
`default_nettype none
// ============================================================================
// Module      : stream_to_axi
// Description : Decodes 64-bit command packets into AXI4 write/read bursts and
//               returns read data as a 64-bit response stream.
// Revision    : 1.0
// ============================================================================
module stream_to_axi #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic [63:0]           s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tlast,
    output logic [63:0]           m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic [ADDR_W-1:0]     m_axi_awaddr,
    output logic [7:0]            m_axi_awlen,
    output logic [2:0]            m_axi_awsize,
    output logic [1:0]            m_axi_awburst,
    output logic                  m_axi_awvalid,
    input  logic                  m_axi_awready,
    output logic [DATA_W-1:0]     m_axi_wdata,
    output logic [DATA_W/8-1:0]   m_axi_wstrb,
    output logic                  m_axi_wlast,
    output logic                  m_axi_wvalid,
    input  logic                  m_axi_wready,
    input  logic [1:0]            m_axi_bresp,
    input  logic                  m_axi_bvalid,
    output logic                  m_axi_bready,
    output logic [ADDR_W-1:0]     m_axi_araddr,
    output logic [7:0]            m_axi_arlen,
    output logic [2:0]            m_axi_arsize,
    output logic [1:0]            m_axi_arburst,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,
    input  logic [DATA_W-1:0]     m_axi_rdata,
    input  logic [1:0]            m_axi_rresp,
    input  logic                  m_axi_rlast,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready,
    output logic [15:0]           err_cnt,
    output logic                  framing_err
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_ADDR = 3'd1,
        WR_DATA = 3'd2,
        WR_RESP = 3'd3,
        RD_ADDR = 3'd4,
        RD_DATA = 3'd5,
        DRAIN   = 3'd6
    } state_t;

    state_t             r_state;
    logic               r_run;
    logic               r_awvalid;
    logic               r_arvalid;
    logic               r_bready;
    logic               r_pad;
    logic               r_drain_pend;
    logic               r_framing;
    logic [ADDR_W-1:0]  r_addr;
    logic [7:0]         r_len;
    logic [7:0]         r_cnt;
    logic [15:0]        r_err_cnt;

    logic w_in_wr;
    logic w_in_rd;
    logic w_wvalid;
    logic w_w_fire;
    logic w_last_beat;
    logic w_s_fire;
    logic w_r_fire;
    logic w_b_fire;
    logic w_hdr;
    logic w_wr_early;
    logic w_wr_notlast;
    logic w_rd_hdr_bad;
    logic w_frame_err;
    logic w_resp_err;
    logic w_unused;

    assign w_in_wr     = (r_state == WR_DATA);
    assign w_in_rd     = (r_state == RD_DATA);
    assign w_last_beat = (r_cnt == r_len);

    // After an early tlast the remaining beats are padded without touching the stream
    assign w_wvalid    = w_in_wr && (r_pad || s_axis_tvalid);
    assign w_w_fire    = w_wvalid && m_axi_wready;

    assign s_axis_tready = (((r_state == IDLE) || (r_state == DRAIN)) && r_run)
                         || (w_in_wr && !r_pad && m_axi_wready);
    assign w_s_fire      = s_axis_tvalid && s_axis_tready;

    assign w_r_fire = w_in_rd && m_axi_rvalid && m_axis_tready;
    assign w_b_fire = r_bready && m_axi_bvalid;

    assign w_hdr        = (r_state == IDLE) && w_s_fire;
    assign w_rd_hdr_bad = w_hdr && s_axis_tdata[63] && !s_axis_tlast;
    assign w_wr_early   = w_w_fire && !r_pad && s_axis_tlast && !w_last_beat;
    assign w_wr_notlast = w_w_fire && !r_pad && !s_axis_tlast && w_last_beat;
    assign w_frame_err  = w_wr_early || w_wr_notlast || w_rd_hdr_bad;
    assign w_resp_err   = (w_b_fire && (m_axi_bresp != 2'b00))
                        || (w_r_fire && (m_axi_rresp != 2'b00));

    assign w_unused = ^{s_axis_tdata[62:56], s_axis_tdata[47:36]};

    assign m_axi_awaddr  = r_addr;
    assign m_axi_awlen   = r_len;
    assign m_axi_awsize  = 3'b010;
    assign m_axi_awburst = 2'b01;
    assign m_axi_awvalid = r_awvalid;

    assign m_axi_wdata   = (w_in_wr && !r_pad) ? s_axis_tdata[DATA_W-1:0] : '0;
    assign m_axi_wstrb   = (w_in_wr && !r_pad) ? s_axis_tdata[35:32] : '0;
    assign m_axi_wlast   = w_in_wr && w_last_beat;
    assign m_axi_wvalid  = w_wvalid;
    assign m_axi_bready  = r_bready;

    assign m_axi_araddr  = r_addr;
    assign m_axi_arlen   = r_len;
    assign m_axi_arsize  = 3'b010;
    assign m_axi_arburst = 2'b01;
    assign m_axi_arvalid = r_arvalid;

    assign m_axis_tdata  = w_in_rd ? {30'b0, m_axi_rresp, m_axi_rdata} : '0;
    assign m_axis_tvalid = w_in_rd && m_axi_rvalid;
    assign m_axis_tlast  = w_in_rd && m_axi_rlast;
    assign m_axi_rready  = w_in_rd && m_axis_tready;

    assign err_cnt     = r_err_cnt;
    assign framing_err = r_framing;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state      <= IDLE;
            r_run        <= 1'b0;
            r_awvalid    <= 1'b0;
            r_arvalid    <= 1'b0;
            r_bready     <= 1'b0;
            r_pad        <= 1'b0;
            r_drain_pend <= 1'b0;
            r_framing    <= 1'b0;
            r_addr       <= '0;
            r_len        <= 8'd0;
            r_cnt        <= 8'd0;
            r_err_cnt    <= 16'd0;
        end else begin
            r_run <= 1'b1;
            // Coincident error sources collapse into a single increment
            if ((w_frame_err || w_resp_err) && (r_err_cnt != 16'hFFFF)) begin
                r_err_cnt <= r_err_cnt + 16'd1;
            end
            if (w_frame_err) begin
                r_framing <= 1'b1;
            end

            case (r_state)
                IDLE: begin
                    if (w_s_fire) begin
                        r_addr <= s_axis_tdata[ADDR_W-1:0];
                        r_len  <= s_axis_tdata[55:48];
                        r_cnt  <= 8'd0;
                        r_pad  <= 1'b0;
                        if (s_axis_tdata[63]) begin
                            r_state      <= RD_ADDR;
                            r_arvalid    <= 1'b1;
                            r_drain_pend <= !s_axis_tlast;
                        end else begin
                            r_state      <= WR_ADDR;
                            r_awvalid    <= 1'b1;
                            r_drain_pend <= 1'b0;
                        end
                    end
                end
                WR_ADDR: begin
                    if (m_axi_awready) begin
                        r_awvalid <= 1'b0;
                        r_state   <= WR_DATA;
                    end
                end
                WR_DATA: begin
                    if (w_w_fire) begin
                        if (w_last_beat) begin
                            r_state  <= WR_RESP;
                            r_bready <= 1'b1;
                            if (w_wr_notlast) begin
                                r_drain_pend <= 1'b1;
                            end
                        end else begin
                            r_cnt <= r_cnt + 8'd1;
                            if (w_wr_early) begin
                                r_pad <= 1'b1;
                            end
                        end
                    end
                end
                WR_RESP: begin
                    if (m_axi_bvalid) begin
                        r_bready <= 1'b0;
                        r_state  <= r_drain_pend ? DRAIN : IDLE;
                    end
                end
                RD_ADDR: begin
                    if (m_axi_arready) begin
                        r_arvalid <= 1'b0;
                        r_state   <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    if (w_r_fire && m_axi_rlast) begin
                        r_state <= r_drain_pend ? DRAIN : IDLE;
                    end
                end
                DRAIN: begin
                    if (w_s_fire && s_axis_tlast) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_stream_to_axi.sv
`default_nettype none
// ============================================================================
// Module      : tb_stream_to_axi
// Description : Directed bench for stream_to_axi with a transaction-level model.
// Revision    : 1.0
// ============================================================================
module tb_stream_to_axi;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic [63:0] s_axis_tdata;
    logic        s_axis_tvalid, s_axis_tready, s_axis_tlast;
    logic [63:0] m_axis_tdata;
    logic        m_axis_tvalid, m_axis_tready, m_axis_tlast;
    logic [31:0] m_axi_awaddr;
    logic [7:0]  m_axi_awlen;
    logic [2:0]  m_axi_awsize;
    logic [1:0]  m_axi_awburst;
    logic        m_axi_awvalid, m_axi_awready;
    logic [31:0] m_axi_wdata;
    logic [3:0]  m_axi_wstrb;
    logic        m_axi_wlast, m_axi_wvalid, m_axi_wready;
    logic [1:0]  m_axi_bresp;
    logic        m_axi_bvalid, m_axi_bready;
    logic [31:0] m_axi_araddr;
    logic [7:0]  m_axi_arlen;
    logic [2:0]  m_axi_arsize;
    logic [1:0]  m_axi_arburst;
    logic        m_axi_arvalid, m_axi_arready;
    logic [31:0] m_axi_rdata;
    logic [1:0]  m_axi_rresp;
    logic        m_axi_rlast, m_axi_rvalid, m_axi_rready;
    logic [15:0] err_cnt;
    logic        framing_err;

    always #5 aclk = ~aclk;

    stream_to_axi #(.ADDR_W(32), .DATA_W(32)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen), .m_axi_awsize(m_axi_awsize),
        .m_axi_awburst(m_axi_awburst), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
        .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize),
        .m_axi_arburst(m_axi_arburst), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
        .err_cnt(err_cnt), .framing_err(framing_err)
    );

    int checks = 0;
    int errors = 0;

    // Model state: pending stream beats and expected channel transactions
    logic [64:0] cmd_q[$];
    logic [39:0] exp_aw_q[$];
    logic [39:0] exp_ar_q[$];
    logic [39:0] ar_pend_q[$];
    logic [37:0] exp_w_q[$];     // {real, last, strb, data}
    logic [64:0] exp_m_q[$];     // {last, tdata}
    int          exp_err = 0;
    logic        exp_fr = 1'b0;
    int          exp_b = 0;
    int          b_fires = 0;
    int          w_fires = 0;
    int          b_pend = 0;
    logic        stall_en = 1'b0;
    logic [1:0]  cfg_bresp = 2'b00;
    logic [1:0]  cfg_rresp = 2'b00;

    logic        s_fire = 0, aw_fire = 0, w_fire = 0, b_fire = 0, ar_fire = 0, r_fire = 0, m_fire = 0;
    logic        r_busy = 0;
    logic [31:0] rd_base = 0;
    logic [7:0]  rd_len = 0, rd_idx = 0;
    logic        pv_aw = 0, pv_w = 0, pv_ar = 0, pv_m = 0;
    logic [39:0] pd_aw, pd_ar;
    logic [36:0] pd_w;
    logic [64:0] pd_m;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s actual=unexpected required=none", name);
    endtask

    function automatic logic [31:0] rd_word(input logic [31:0] a, input logic [7:0] i);
        return a ^ {i, 24'h5AC30F};
    endfunction

    // A write packet of n data beats, tlast on the final sent beat
    task automatic send_write(input logic [31:0] addr, input logic [7:0] len, input int n,
                              input logic [31:0] dbase);
        cmd_q.push_back({1'b0, 1'b0, 7'h55, len, 16'hBEEF, addr});
        for (int i = 0; i < n; i++)
            cmd_q.push_back({(i == n - 1), 28'hBADF00D, 4'hF ^ 4'(i), dbase + 32'(i)});
        exp_aw_q.push_back({addr, len});
        for (int i = 0; i <= int'(len); i++) begin
            if (i < n) exp_w_q.push_back({1'b1, (i == int'(len)), 4'hF ^ 4'(i), dbase + 32'(i)});
            else       exp_w_q.push_back({1'b0, (i == int'(len)), 4'h0, 32'h0});
        end
        if (n != int'(len) + 1) begin
            exp_err++;
            exp_fr = 1'b1;
        end
        if (cfg_bresp != 2'b00) exp_err++;
        exp_b++;
    endtask

    task automatic send_read(input logic [31:0] addr, input logic [7:0] len,
                             input logic with_last, input int extra);
        cmd_q.push_back({with_last, 1'b1, 7'h2A, len, 16'h1234, addr});
        for (int i = 0; i < extra; i++)
            cmd_q.push_back({(i == extra - 1), 64'hF000_0000_0000_0000 | 64'(i)});
        exp_ar_q.push_back({addr, len});
        for (int i = 0; i <= int'(len); i++)
            exp_m_q.push_back({(i == int'(len)), 30'b0, cfg_rresp, rd_word(addr, 8'(i))});
        if (cfg_rresp != 2'b00) exp_err += int'(len) + 1;
        if (!with_last) begin
            exp_err++;
            exp_fr = 1'b1;
        end
    endtask

    task automatic check_reset_outputs(input string name);
        chk({name, "_ctl"}, {s_axis_tready, m_axis_tvalid, m_axis_tlast, m_axi_awvalid, m_axi_wvalid,
                             m_axi_wlast, m_axi_bready, m_axi_arvalid, m_axi_rready}, 0);
        chk({name, "_addr"}, {m_axi_awaddr, m_axi_araddr, m_axi_awlen, m_axi_arlen}, 0);
        chk({name, "_data"}, {m_axis_tdata, m_axi_wdata, m_axi_wstrb}, 0);
        chk({name, "_err"}, {err_cnt, framing_err}, 0);
    endtask

    task automatic clear_model();
        cmd_q.delete(); exp_aw_q.delete(); exp_ar_q.delete(); ar_pend_q.delete();
        exp_w_q.delete(); exp_m_q.delete();
        exp_err = 0; exp_fr = 1'b0; exp_b = 0; b_fires = 0; w_fires = 0; b_pend = 0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((cmd_q.size() > 0 || exp_aw_q.size() > 0 || exp_w_q.size() > 0 ||
                exp_ar_q.size() > 0 || exp_m_q.size() > 0 || ar_pend_q.size() > 0 ||
                b_pend > 0 || m_axi_bvalid || r_busy) && n < 20000) begin
            @(negedge aclk);
            n++;
        end
        if (n >= 20000) chk({name, "_timeout"}, {cmd_q.size(), exp_w_q.size(), exp_m_q.size()}, 0);
        repeat (3) @(negedge aclk);
    endtask

    task automatic status(input string name, input logic [15:0] lit_err, input logic lit_fr);
        chk({name, "_err_lit"}, err_cnt, lit_err);
        chk({name, "_err_model"}, err_cnt, 16'(exp_err));
        chk({name, "_framing"}, framing_err, lit_fr);
        chk({name, "_framing_model"}, framing_err, exp_fr);
        chk({name, "_bresp_count"}, b_fires, exp_b);
    endtask

    // Stream source and AXI slave, updated just after each rising edge
    initial begin
        s_axis_tdata = '0; s_axis_tvalid = 0; s_axis_tlast = 0; m_axis_tready = 0;
        m_axi_awready = 0; m_axi_wready = 0; m_axi_bresp = 0; m_axi_bvalid = 0;
        m_axi_arready = 0; m_axi_rdata = 0; m_axi_rresp = 0; m_axi_rlast = 0; m_axi_rvalid = 0;
        forever begin
            @(posedge aclk);
            #1;
            if (!aresetn) begin
                s_axis_tvalid = 0; s_axis_tdata = '0; s_axis_tlast = 0;
                m_axi_bvalid = 0; m_axi_bresp = 0; m_axi_rvalid = 0; m_axi_rlast = 0;
                m_axi_rdata = 0; m_axi_rresp = 0; r_busy = 0;
            end else begin
                if (s_fire && cmd_q.size() > 0) void'(cmd_q.pop_front());
                if (cmd_q.size() > 0) begin
                    s_axis_tvalid = 1;
                    {s_axis_tlast, s_axis_tdata} = cmd_q[0];
                end else begin
                    s_axis_tvalid = 0; s_axis_tlast = 0; s_axis_tdata = '0;
                end
                m_axi_awready = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
                m_axi_wready  = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
                m_axi_arready = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
                m_axis_tready = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
                if (b_fire) m_axi_bvalid = 0;
                if (!m_axi_bvalid && b_pend > 0) begin
                    m_axi_bvalid = 1; m_axi_bresp = cfg_bresp; b_pend--;
                end
                if (r_fire) begin
                    if (rd_idx == rd_len) r_busy = 0;
                    else rd_idx = rd_idx + 8'd1;
                end
                if (!r_busy && ar_pend_q.size() > 0) begin
                    {rd_base, rd_len} = ar_pend_q.pop_front();
                    rd_idx = 0;
                    r_busy = 1;
                end
                m_axi_rvalid = r_busy;
                m_axi_rdata  = r_busy ? rd_word(rd_base, rd_idx) : 32'h0;
                m_axi_rresp  = r_busy ? cfg_rresp : 2'b00;
                m_axi_rlast  = r_busy && (rd_idx == rd_len);
            end
        end
    end

    // Compare process: every handshake and every stalled valid, at the falling edge
    initial begin
        logic [37:0] ew;
        logic [39:0] ea;
        logic [64:0] em;
        forever begin
            @(negedge aclk);
            s_fire  = aresetn && s_axis_tvalid && s_axis_tready;
            aw_fire = aresetn && m_axi_awvalid && m_axi_awready;
            w_fire  = aresetn && m_axi_wvalid && m_axi_wready;
            b_fire  = aresetn && m_axi_bvalid && m_axi_bready;
            ar_fire = aresetn && m_axi_arvalid && m_axi_arready;
            r_fire  = aresetn && m_axi_rvalid && m_axi_rready;
            m_fire  = aresetn && m_axis_tvalid && m_axis_tready;
            if (!aresetn) begin
                pv_aw = 0; pv_w = 0; pv_ar = 0; pv_m = 0;
            end else begin
                if (aw_fire) begin
                    if (exp_aw_q.size() == 0) fail("aw_extra");
                    else begin ea = exp_aw_q.pop_front(); chk("aw", {m_axi_awaddr, m_axi_awlen}, ea); end
                end
                if (w_fire) begin
                    w_fires++;
                    if (exp_w_q.size() == 0) fail("w_extra");
                    else begin
                        ew = exp_w_q.pop_front();
                        chk("w_last_strb", {m_axi_wlast, m_axi_wstrb}, ew[36:32]);
                        if (ew[37]) chk("w_data", m_axi_wdata, ew[31:0]);
                        if (ew[36]) b_pend++;
                    end
                end
                if (b_fire) b_fires++;
                if (ar_fire) begin
                    ar_pend_q.push_back({m_axi_araddr, m_axi_arlen});
                    if (exp_ar_q.size() == 0) fail("ar_extra");
                    else begin ea = exp_ar_q.pop_front(); chk("ar", {m_axi_araddr, m_axi_arlen}, ea); end
                end
                if (m_fire) begin
                    if (exp_m_q.size() == 0) fail("m_extra");
                    else begin em = exp_m_q.pop_front(); chk("m_beat", {m_axis_tlast, m_axis_tdata}, em); end
                end
                if (pv_aw) chk("aw_hold", {m_axi_awvalid, m_axi_awaddr, m_axi_awlen}, {1'b1, pd_aw});
                if (pv_w)  chk("w_hold", {m_axi_wvalid, m_axi_wlast, m_axi_wstrb, m_axi_wdata}, {1'b1, pd_w});
                if (pv_ar) chk("ar_hold", {m_axi_arvalid, m_axi_araddr, m_axi_arlen}, {1'b1, pd_ar});
                if (pv_m)  chk("m_hold", {m_axis_tvalid, m_axis_tlast, m_axis_tdata}, {1'b1, pd_m});
                pv_aw = m_axi_awvalid && !m_axi_awready; pd_aw = {m_axi_awaddr, m_axi_awlen};
                pv_w  = m_axi_wvalid && !m_axi_wready;   pd_w  = {m_axi_wlast, m_axi_wstrb, m_axi_wdata};
                pv_ar = m_axi_arvalid && !m_axi_arready; pd_ar = {m_axi_araddr, m_axi_arlen};
                pv_m  = m_axis_tvalid && !m_axis_tready; pd_m  = {m_axis_tlast, m_axis_tdata};
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        aresetn = 1'b0;
        #23;
        check_reset_outputs("reset");
        chk("const_size_burst", {m_axi_awsize, m_axi_awburst, m_axi_arsize, m_axi_arburst},
            {3'b010, 2'b01, 3'b010, 2'b01});
        @(negedge aclk); #2 aresetn = 1'b1;

        // Plain write: four beats 0xA..0xD
        send_write(32'h1000, 8'd3, 4, 32'hA);
        wait_idle("wr_basic");
        status("wr_basic", 16'd0, 1'b0);

        // Plain read of two beats
        send_read(32'h2000, 8'd1, 1'b1, 0);
        wait_idle("rd_basic");
        status("rd_basic", 16'd0, 1'b0);

        // SLVERR on B, then DECERR on a single R beat
        cfg_bresp = 2'b10;
        send_write(32'h1100, 8'd0, 1, 32'h77);
        wait_idle("wr_slverr");
        cfg_bresp = 2'b00;
        cfg_rresp = 2'b11;
        send_read(32'h2100, 8'd0, 1'b1, 0);
        wait_idle("rd_decerr");
        cfg_rresp = 2'b00;
        status("resp_errs", 16'd2, 1'b0);

        @(negedge aclk); #2 aresetn = 1'b0;
        #1 check_reset_outputs("reset2");
        clear_model();
        @(negedge aclk); @(negedge aclk); #2 aresetn = 1'b1;

        // Early tlast: two real beats, two padded
        send_write(32'h1200, 8'd3, 2, 32'h100);
        wait_idle("wr_early");
        status("wr_early", 16'd1, 1'b1);

        // Missing tlast on final beat: two extra beats drained
        send_write(32'h1300, 8'd1, 4, 32'h200);
        wait_idle("wr_notlast");
        status("wr_notlast", 16'd2, 1'b1);

        // Read header without tlast: trailing beats drained
        send_read(32'h1400, 8'd2, 1'b0, 2);
        wait_idle("rd_notlast");
        status("rd_notlast", 16'd3, 1'b1);

        // Maximum bursts under random back-pressure
        stall_en = 1'b1;
        send_write(32'h3000, 8'd255, 256, 32'h1_0000);
        wait_idle("wr_256");
        send_read(32'h4000, 8'd255, 1'b1, 0);
        wait_idle("rd_256");
        stall_en = 1'b0;
        status("long_bursts", 16'd3, 1'b1);

        // Reset while the third W beat is pending
        w_fires = 0;
        send_write(32'h5000, 8'd3, 4, 32'h300);
        n = 0;
        while (w_fires < 2 && n < 1000) begin @(negedge aclk); n++; end
        chk("mid_burst_reach", w_fires, 2);
        #2 aresetn = 1'b0;
        #1 check_reset_outputs("reset_mid");
        clear_model();
        @(negedge aclk); @(negedge aclk); #2 aresetn = 1'b1;
        send_read(32'h6000, 8'd2, 1'b1, 0);
        wait_idle("rd_after_reset");
        status("rd_after_reset", 16'd0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/stream_to_axi.md
STREAM_TO_AXI -- requirements
Module: stream_to_axi

Interface
REQ-001 Parameter ADDR_W, default 32: AXI address width; the only supported value is 32.
REQ-002 Parameter DATA_W, default 32: AXI data width; the only supported value is 32; stream width is fixed at 64.
REQ-003 aclk  in  1  sole clock; all logic is rising-edge.
REQ-004 aresetn  in  1  reset, asynchronous assert, active-low.
REQ-005 s_axis_tdata/tvalid/tready/tlast  in/in/out/in  64/1/1/1  command stream carrying encoded AXI transactions.
REQ-006 m_axis_tdata/tvalid/tready/tlast  out/out/in/out  64/1/1/1  read-response stream.
REQ-007 m_axi_awaddr/awlen/awsize/awburst/awvalid/awready  out×5/in  32/8/3/2/1/1  AXI4 write address.
REQ-008 m_axi_wdata/wstrb/wlast/wvalid/wready  out×4/in  32/4/1/1/1  AXI4 write data.
REQ-009 m_axi_bresp/bvalid/bready  in/in/out  2/1/1  AXI4 write response.
REQ-010 m_axi_araddr/arlen/arsize/arburst/arvalid/arready  out×5/in  32/8/3/2/1/1  AXI4 read address.
REQ-011 m_axi_rdata/rresp/rlast/rvalid/rready  in×4/out  32/2/1/1/1  AXI4 read data.
REQ-012 err_cnt  out  16  count of non-OKAY responses plus framing errors, saturating.
REQ-013 framing_err  out  1  sticky flag, set on malformed command packet.

Function
REQ-014 Header beat: [63]=rnw (1 = read), [55:48]=len, [31:0]=addr; all other bits are ignored.
REQ-015 Write packet: header followed by len+1 data beats, each with wdata=[31:0] and wstrb=[35:32]; tlast is asserted on the final data beat only.
REQ-016 Read packet: header only, with tlast=1.
REQ-017 awsize/arsize SHALL be 3'b010 and awburst/arburst SHALL be 2'b01 (INCR), constant.
REQ-018 FSM states: IDLE, WR_ADDR, WR_DATA, WR_RESP, RD_ADDR, RD_DATA, DRAIN.
REQ-019 IDLE: s_axis_tready=1; a header handshake latches addr and len, then moves to WR_ADDR or RD_ADDR on the next cycle.
REQ-020 WR_ADDR: awvalid=1 holding latched addr and len until awready; then WR_DATA. AW and W are never overlapped.
REQ-021 WR_DATA: s_axis_tready=m_axi_wready and wvalid=s_axis_tvalid, combinationally passed through. wlast is asserted when the beat counter equals len.
REQ-022 WR_DATA: after the beat with counter==len transfers, the FSM moves to WR_RESP.
REQ-023 WR_DATA: if s_axis_tlast arrives with counter<len, the FSM sets framing_err and increments err_cnt. It then issues the remaining W beats with wstrb=0 (stream not consumed) and moves to WR_RESP.
REQ-024 WR_DATA: if the beat with counter==len has tlast=0, that beat is still written. The FSM then sets framing_err, increments err_cnt, and moves to DRAIN after the B response.
REQ-025 WR_RESP: bready=1; on bvalid, err_cnt increments if bresp!=2'b00; then IDLE (or DRAIN per REQ-024).
REQ-026 RD_ADDR: arvalid=1 until arready; then RD_DATA. A read header with tlast=0 sets framing_err, and the FSM goes to DRAIN after RD_DATA.
REQ-027 RD_DATA: m_axis_tdata={30'b0, rresp, rdata}, m_axis_tvalid=rvalid, rready=m_axis_tready, m_axis_tlast=rlast.
REQ-028 RD_DATA: err_cnt increments per beat with rresp!=0; the FSM returns to IDLE after the rlast handshake.
REQ-029 DRAIN: s_axis_tready=1 and beats are discarded up to and including the tlast beat; then IDLE.
REQ-030 Beat counter is 8 bits and resets to 0 per transaction; len=255 gives 256 beats with no wrap error.
REQ-031 err_cnt saturates at 16'hFFFF; simultaneous error sources in one cycle add +1 only.
REQ-032 All *valid outputs SHALL never drop before their handshake completes; all AXI outputs are stable while valid && !ready.
REQ-033 In IDLE, s_axis_tready=1 even when m_axis is back-pressured; read data waits in RD_DATA.

Reset
REQ-034 On aresetn=0 the FSM goes to IDLE; every valid/ready output is 0, err_cnt=0, framing_err=0, and address/data outputs are 0, all asynchronously.
REQ-035 Reset mid-burst abandons the transaction without completion; the first post-reset cycle with aresetn=1 may accept a header.

Verification
REQ-036 Write header addr=0x1000, len=3, then 4 data beats 0xA..0xD with tlast on the 4th -> one AW (awlen=3), 4 W beats with wlast on the 4th, bready seen, err_cnt=0.
REQ-037 Read header addr=0x2000, len=1, tlast=1, slave returns 2 beats with rresp=0 -> m_axis emits 2 beats with tlast on the 2nd and tdata[33:32]=0.
REQ-038 Write len=3 with tlast on the 2nd data beat -> 2 real beats and 2 beats with wstrb=0, framing_err=1, err_cnt=1.
REQ-039 Write len=0 with bresp=2'b10, followed by a read with rresp=2'b11 on 1 beat -> err_cnt=2, framing_err=0.
REQ-040 Random awready/wready/m_axis_tready stalls across a len=255 write and read -> 256 beats each, payload intact, no valid drop.
REQ-041 aresetn pulsed low during WR_DATA beat 2 -> all outputs 0 immediately; a new read command completes normally after release.
